multiplicacao_matrizes_seq: RTL and testbench
=============================================

# multiplicacao_matrizes_seq

Sequential, parametrised signed matrix multiplier computing C = A × B for square N×N matrices of W-bit two's-complement elements. It uses a single multiply-accumulate datapath iterated over i/j/k counters, with a start/done handshake, selectable wrap or saturate output mode and per-element overflow reporting. It is the area-reduced successor to the combinational 5×5 int8 multiplier and keeps the same row-major linearised operand layout.

## Interface
- N, default 5: matrix dimension (2..8)
- W, default 8: element width in bits, signed
- SAT, default 1: 1 = clamp out-of-range results to the W-bit signed limits, 0 = keep the low W bits (wrap)
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a multiplication; sampled only in IDLE
- A  input  N*N*W  matrix A, element (i,j) at bits [(i*N+j)*W +: W], signed
- B  input  N*N*W  matrix B, same layout
- busy  output  1  high in CALC and DONE
- done  output  1  one-cycle pulse: C, overflow_flag and ovf_mask are valid
- C  output  N*N*W  result matrix, same layout
- overflow_flag  output  1  OR of ovf_mask for the last run
- ovf_mask  output  N*N  bit i*N+j set if element (i,j) exceeded the W-bit signed range

## Operation
- FSM states:
  - IDLE: start=1 latches A and B into internal operand registers, clears the accumulator, i/j/k counters, ovf_mask and overflow_flag, and goes to CALC.
  - CALC: one MAC per cycle, acc += A[i][k]*B[k][j].
    - When k==N-1, the final sum (acc + product) is range-checked, written to C(i,j) and ovf_mask(i,j), and acc is cleared. Then k wraps and j advances; on j wrap, i advances.
    - After the element (N-1,N-1) write, the FSM goes to DONE.
  - DONE: done=1 for one cycle, then unconditionally back to IDLE.
- Accumulator width: 2W + clog2(N) bits, signed. No internal overflow is possible.
- Range check: an element overflows if the sum is < -2^(W-1) or > 2^(W-1)-1.
  - SAT=1: the result is clamped to the nearest limit.
  - SAT=0: the result is the low W bits.
  - The mask bit is set in both modes.
- Operands are taken from the latched copies. Changes on A and B after start is accepted have no effect.
- C is updated element by element during CALC. It is guaranteed coherent from done until the next accepted start, and holds its value while in IDLE.
- start is ignored while busy=1, including in the DONE cycle.

## Timing
- Reset values: state IDLE; busy, done, overflow_flag = 0; C, ovf_mask, accumulator, counters = 0.
- Latency: if start is sampled at edge e0, done is high after edge e0+N³ and low again after edge e0+N³+1. For N=5 this is 125 edges.
- busy rises after e0 and falls with done.
- Back-to-back runs: a start held high re-triggers on the first IDLE cycle. The minimum start-to-start period is N³+2 cycles.
- Reset mid-CALC: all state clears immediately (asynchronous). No done pulse is produced, and C returns to 0.
- Single-cycle MAC path (multiply plus add). There are no pipeline stages.

## Structure
- Package multiplicacao_pkg:
  - FSM state enum (IDLE, CALC, DONE).
  - Function for accumulator width.
  - Saturate/wrap helper function taking (value, W, SAT).
- Sub-module mac_elemento: the accumulator register, multiply-add, and range check/saturation logic. Interface is clear, operands, last flag, result, overflow bit.
- The top level holds the FSM, the counters, the operand latches and the C/ovf_mask registers.

## Test plan
- N=5, W=8, SAT=1: A = identity, B(i,j)=i+j → C = B, ovf_mask=0, overflow_flag=0, done exactly 125 edges after the start edge, one-cycle wide.
- N=5, A and B all 127: SAT=1 → every C element = 127, ovf_mask all ones. SAT=0 → every element = 5 (80645 mod 256).
- N=5, A all -100, B all 1: SAT=1 → every element = -128. SAT=0 → every element = 12. overflow_flag=1 in both.
- N=3, A=B=[[1,2,3],[4,5,6],[7,8,9]], SAT=1 → C=[[30,36,42],[66,81,96],[102,126,127]], ovf_mask = only bit 8, done after 27 edges.
- Pulse start again mid-CALC and change A mid-run → ignored; result matches the originally latched A. Hold start high → second run begins immediately after DONE.
- Assert rst_n low mid-CALC → busy, done and C drop to 0 with no clock edge needed. The next start completes normally.

Source files
------------

// File: rtl/multiplicacao_pkg.sv
// Shared types and helpers for the sequential signed matrix multiplier.
//   state_t     : controller states (IDLE, CALC, DONE)
//   acc_width   : accumulator width that cannot overflow for an N-term dot product
//   sat_wrap    : clamps a wide signed value to the W-bit range (sat=1) or passes it
//                 through unchanged so the caller keeps its low W bits (sat=0)
//   is_ovf      : flags a wide signed value that lies outside the W-bit signed range
package multiplicacao_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  function automatic int acc_width(input int n, input int w);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return 2 * w + r;
  endfunction

  function automatic logic signed [63:0] sat_wrap(input logic signed [63:0] value,
                                                  input int w, input bit sat);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (sat && value > hi) return hi;
    if (sat && value < lo) return lo;
    return value;
  endfunction

  function automatic logic is_ovf(input logic signed [63:0] value, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    return (value > hi) || (value < lo);
  endfunction

endpackage

// File: rtl/multiplicacao_matrizes_seq_mac.sv
// Single multiply-accumulate element with output range check.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : zero the accumulator (start of a run)
//   en         : accumulate this cycle
//   last       : final term of the dot product; acc is cleared after it
//   a, b       : signed W-bit operands
//   result     : W-bit value of acc + a*b, clamped or wrapped per SAT
//   ovf        : acc + a*b lies outside the W-bit signed range
module mac_elemento
  import multiplicacao_pkg::*;
#(
  parameter int N   = 5,
  parameter int W   = 8,
  parameter int SAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                en,
  input  logic                last,
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic        [W-1:0] result,
  output logic                ovf
);

  localparam int AW = acc_width(N, W);
  localparam int PW = 2 * W;

  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] sum;
  logic signed [PW-1:0] prod;
  logic signed [63:0]   sum64;
  logic signed [63:0]   lim64;

  always_comb begin
    prod   = PW'(a) * PW'(b);
    sum    = acc + AW'(prod);
    sum64  = 64'(sum);
    lim64  = sat_wrap(sum64, W, SAT != 0);
    result = lim64[W-1:0];
    ovf    = is_ovf(sum64, W);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= last ? '0 : sum;
    end
  end

endmodule

// File: rtl/multiplicacao_matrizes_seq.sv
// Sequential signed N x N matrix multiplier, C = A x B, one MAC per cycle.
//   clk, rst_n     : clock, asynchronous active-low reset
//   start          : request a run (sampled only in IDLE)
//   A, B           : row-major operands, element (i,j) at [(i*N+j)*W +: W]
//   busy           : high in CALC and DONE
//   done           : one-cycle pulse, C/ovf_mask/overflow_flag valid
//   C              : result matrix, same layout, written element by element
//   overflow_flag  : OR of ovf_mask for the last run
//   ovf_mask       : bit i*N+j set if element (i,j) left the W-bit range
module multiplicacao_matrizes_seq
  import multiplicacao_pkg::*;
#(
  parameter int N   = 5,
  parameter int W   = 8,
  parameter int SAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [N*N*W-1:0] A,
  input  logic [N*N*W-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [N*N*W-1:0] C,
  output logic             overflow_flag,
  output logic [N*N-1:0]   ovf_mask
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t state, state_next;

  logic [N*N*W-1:0]   a_reg, b_reg;
  logic [CW-1:0]      i, j, k;
  logic               mac_clear, mac_en, last_k, last_elem;
  logic signed [W-1:0] a_op, b_op;
  logic [W-1:0]       mac_result;
  logic               mac_ovf;
  int                 a_idx, b_idx, c_idx;

  always_comb begin
    a_idx     = int'(i) * N + int'(k);
    b_idx     = int'(k) * N + int'(j);
    c_idx     = int'(i) * N + int'(j);
    a_op      = a_reg[a_idx*W +: W];
    b_op      = b_reg[b_idx*W +: W];
    last_k    = (k == LAST);
    last_elem = last_k && (j == LAST) && (i == LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    mac_clear  = 1'b0;
    mac_en     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_next = CALC;
          mac_clear  = 1'b1;
        end
      end
      CALC: begin
        busy   = 1'b1;
        mac_en = 1'b1;
        if (last_elem) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  mac_elemento #(.N(N), .W(W), .SAT(SAT)) u_mac (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (mac_clear),
    .en     (mac_en),
    .last   (last_k),
    .a      (a_op),
    .b      (b_op),
    .result (mac_result),
    .ovf    (mac_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg         <= '0;
      b_reg         <= '0;
      i             <= '0;
      j             <= '0;
      k             <= '0;
      C             <= '0;
      ovf_mask      <= '0;
      overflow_flag <= 1'b0;
    end else if (mac_clear) begin
      a_reg         <= A;
      b_reg         <= B;
      i             <= '0;
      j             <= '0;
      k             <= '0;
      ovf_mask      <= '0;
      overflow_flag <= 1'b0;
    end else if (mac_en) begin
      if (last_k) begin
        C[c_idx*W +: W]  <= mac_result;
        ovf_mask[c_idx]  <= mac_ovf;
        overflow_flag    <= overflow_flag | mac_ovf;
        k                <= '0;
        if (j == LAST) begin
          j <= '0;
          i <= (i == LAST) ? '0 : i + 1'b1;
        end else begin
          j <= j + 1'b1;
        end
      end else begin
        k <= k + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_multiplicacao_matrizes_seq.sv
module tb_multiplicacao_matrizes_seq;

  localparam int W  = 8;
  localparam int N5 = 5;
  localparam int N3 = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start5 = 1'b0;
  logic start3 = 1'b0;

  logic [N5*N5*W-1:0] a5 = '0, b5 = '0, c5s, c5w;
  logic               busy5s, done5s, ovf5s, busy5w, done5w, ovf5w;
  logic [N5*N5-1:0]   mask5s, mask5w;

  logic [N3*N3*W-1:0] a3 = '0, b3 = '0, c3;
  logic               busy3, done3, ovf3;
  logic [N3*N3-1:0]   mask3;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  multiplicacao_matrizes_seq #(.N(N5), .W(W), .SAT(1)) u5s (
    .clk(clk), .rst_n(rst_n), .start(start5), .A(a5), .B(b5),
    .busy(busy5s), .done(done5s), .C(c5s), .overflow_flag(ovf5s), .ovf_mask(mask5s));

  multiplicacao_matrizes_seq #(.N(N5), .W(W), .SAT(0)) u5w (
    .clk(clk), .rst_n(rst_n), .start(start5), .A(a5), .B(b5),
    .busy(busy5w), .done(done5w), .C(c5w), .overflow_flag(ovf5w), .ovf_mask(mask5w));

  multiplicacao_matrizes_seq #(.N(N3), .W(W), .SAT(1)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .A(a3), .B(b3),
    .busy(busy3), .done(done3), .C(c3), .overflow_flag(ovf3), .ovf_mask(mask3));

  // Pulses start5 for one edge, then counts edges since that start edge until done.
  task automatic run5(output int lat, output logic busy0);
    @(negedge clk); start5 = 1'b1;
    @(negedge clk); start5 = 1'b0;
    busy0 = busy5s;
    lat = 0;
    while (!done5s && lat < 400) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic set_m3;
    for (int i = 0; i < N3; i++)
      for (int j = 0; j < N3; j++) begin
        a3[(i*N3+j)*W +: W] = 8'(3*i + j + 1);
        b3[(i*N3+j)*W +: W] = 8'(3*i + j + 1);
      end
  endtask

  function automatic logic [N3*N3*W-1:0] exp_m3();
    int e[9] = '{30, 36, 42, 66, 81, 96, 102, 126, 127};
    logic [N3*N3*W-1:0] v;
    v = '0;
    for (int n = 0; n < 9; n++) v[n*W +: W] = 8'(e[n]);
    return v;
  endfunction

  task automatic test_reset;
    #1;
    total_cnt++; if (busy5s !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy5s); else pass_cnt++;
    total_cnt++; if (done5s !== 1'b0) $display("FAIL reset_done: got %b expected 0", done5s); else pass_cnt++;
    total_cnt++; if (c5s !== '0) $display("FAIL reset_c: got %h expected 0", c5s); else pass_cnt++;
    total_cnt++; if (mask5s !== '0 || ovf5s !== 1'b0)
      $display("FAIL reset_ovf: got mask %h flag %b expected 0/0", mask5s, ovf5s); else pass_cnt++;
    total_cnt++; if (busy3 !== 1'b0 || c3 !== '0)
      $display("FAIL reset_n3: got busy %b c %h expected 0/0", busy3, c3); else pass_cnt++;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_identity;
    int lat;
    logic busy0;
    logic [N5*N5*W-1:0] exp;
    for (int i = 0; i < N5; i++)
      for (int j = 0; j < N5; j++) begin
        a5[(i*N5+j)*W +: W] = (i == j) ? 8'd1 : 8'd0;
        b5[(i*N5+j)*W +: W] = 8'(i + j);
      end
    exp = b5;
    run5(lat, busy0);
    total_cnt++; if (busy0 !== 1'b1) $display("FAIL ident_busy_rise: got %b expected 1", busy0); else pass_cnt++;
    total_cnt++; if (lat != 125) $display("FAIL ident_latency: got %0d expected 125", lat); else pass_cnt++;
    total_cnt++; if (c5s !== exp) $display("FAIL ident_c_sat: got %h expected %h", c5s, exp); else pass_cnt++;
    total_cnt++; if (c5w !== exp) $display("FAIL ident_c_wrap: got %h expected %h", c5w, exp); else pass_cnt++;
    total_cnt++; if (mask5s !== '0 || ovf5s !== 1'b0)
      $display("FAIL ident_ovf: got mask %h flag %b expected 0/0", mask5s, ovf5s); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (done5s !== 1'b0 || busy5s !== 1'b0)
      $display("FAIL ident_done_width: got done %b busy %b expected 0/0", done5s, busy5s); else pass_cnt++;
  endtask

  task automatic test_max_positive;
    int lat;
    logic busy0;
    a5 = {25{8'd127}};
    b5 = {25{8'd127}};
    run5(lat, busy0);
    total_cnt++; if (lat != 125) $display("FAIL max_latency: got %0d expected 125", lat); else pass_cnt++;
    total_cnt++; if (c5s !== {25{8'd127}}) $display("FAIL max_c_sat: got %h expected all 7f", c5s); else pass_cnt++;
    total_cnt++; if (c5w !== {25{8'd5}}) $display("FAIL max_c_wrap: got %h expected all 05", c5w); else pass_cnt++;
    total_cnt++; if (mask5s !== {25{1'b1}} || ovf5s !== 1'b1)
      $display("FAIL max_ovf_sat: got mask %h flag %b expected 1ffffff/1", mask5s, ovf5s); else pass_cnt++;
    total_cnt++; if (mask5w !== {25{1'b1}} || ovf5w !== 1'b1)
      $display("FAIL max_ovf_wrap: got mask %h flag %b expected 1ffffff/1", mask5w, ovf5w); else pass_cnt++;
  endtask

  task automatic test_negative;
    int lat;
    logic busy0;
    a5 = {25{8'h9C}};  // -100
    b5 = {25{8'h01}};
    run5(lat, busy0);
    total_cnt++; if (c5s !== {25{8'h80}}) $display("FAIL neg_c_sat: got %h expected all 80", c5s); else pass_cnt++;
    total_cnt++; if (c5w !== {25{8'h0C}}) $display("FAIL neg_c_wrap: got %h expected all 0c", c5w); else pass_cnt++;
    total_cnt++; if (ovf5s !== 1'b1 || ovf5w !== 1'b1)
      $display("FAIL neg_flag: got sat %b wrap %b expected 1/1", ovf5s, ovf5w); else pass_cnt++;
    total_cnt++; if (mask5w !== {25{1'b1}}) $display("FAIL neg_mask_wrap: got %h expected 1ffffff", mask5w); else pass_cnt++;
  endtask

  // N=3 run; restarts and operand changes mid-run must be ignored.
  task automatic test_n3_midrun;
    int lat;
    set_m3();
    @(negedge clk); start3 = 1'b1;
    @(negedge clk); start3 = 1'b0;
    lat = 0;
    while (!done3 && lat < 200) begin
      @(negedge clk);
      lat++;
      if (lat == 5) begin a3 = '0; b3 = '0; start3 = 1'b1; end
      if (lat == 6) start3 = 1'b0;
    end
    total_cnt++; if (lat != 27) $display("FAIL n3_latency: got %0d expected 27", lat); else pass_cnt++;
    total_cnt++; if (c3 !== exp_m3()) $display("FAIL n3_c: got %h expected %h", c3, exp_m3()); else pass_cnt++;
    total_cnt++; if (mask3 !== 9'h100 || ovf3 !== 1'b1)
      $display("FAIL n3_ovf: got mask %h flag %b expected 100/1", mask3, ovf3); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (busy3 !== 1'b0 || c3 !== exp_m3())
      $display("FAIL n3_hold_idle: got busy %b c %h expected 0/%h", busy3, c3, exp_m3()); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int lat;
    set_m3();
    @(negedge clk); start3 = 1'b1;
    @(negedge clk);
    lat = 0;
    while (!done3 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    total_cnt++; if (lat != 27) $display("FAIL b2b_first_latency: got %0d expected 27", lat); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (busy3 !== 1'b0 || done3 !== 1'b0)
      $display("FAIL b2b_idle_gap: got busy %b done %b expected 0/0", busy3, done3); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (busy3 !== 1'b1) $display("FAIL b2b_retrigger: got busy %b expected 1", busy3); else pass_cnt++;
    start3 = 1'b0;
    lat = 0;
    while (!done3 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    total_cnt++; if (lat != 27) $display("FAIL b2b_second_latency: got %0d expected 27", lat); else pass_cnt++;
    total_cnt++; if (c3 !== exp_m3()) $display("FAIL b2b_c: got %h expected %h", c3, exp_m3()); else pass_cnt++;
  endtask

  task automatic test_reset_midcalc;
    int lat;
    logic busy0;
    a5 = {25{8'd127}};
    b5 = {25{8'd127}};
    @(negedge clk); start5 = 1'b1;
    @(negedge clk); start5 = 1'b0;
    repeat (30) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    total_cnt++; if (busy5s !== 1'b0 || done5s !== 1'b0)
      $display("FAIL rstmid_ctrl: got busy %b done %b expected 0/0", busy5s, done5s); else pass_cnt++;
    total_cnt++; if (c5s !== '0 || c5w !== '0)
      $display("FAIL rstmid_c: got %h / %h expected 0", c5s, c5w); else pass_cnt++;
    total_cnt++; if (mask5s !== '0 || ovf5s !== 1'b0)
      $display("FAIL rstmid_ovf: got mask %h flag %b expected 0/0", mask5s, ovf5s); else pass_cnt++;
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < N5; i++)
      for (int j = 0; j < N5; j++) begin
        a5[(i*N5+j)*W +: W] = (i == j) ? 8'd1 : 8'd0;
        b5[(i*N5+j)*W +: W] = 8'(i + j);
      end
    run5(lat, busy0);
    total_cnt++; if (lat != 125) $display("FAIL rstmid_rerun_latency: got %0d expected 125", lat); else pass_cnt++;
    total_cnt++; if (c5s !== b5) $display("FAIL rstmid_rerun_c: got %h expected %h", c5s, b5); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_identity();
    test_max_positive();
    test_negative();
    test_n3_midrun();
    test_back_to_back();
    test_reset_midcalc();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
